// File: rtl/matlab_pkg.sv
// Shared MATLAB reorder encodings and the byte permutation used by both the
// transmit-side reorder stage and the receive-side restore stage.
package matlab_pkg;

    localparam logic [1:0] MCONF_NONE   = 2'b00;
    localparam logic [1:0] MCONF_NIB    = 2'b01;
    localparam logic [1:0] MCONF_PAIR   = 2'b10;
    localparam logic [1:0] MCONF_BITREV = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Every mode is an involution, so this one function both reorders and restores.
    function automatic logic [7:0] matlab_perm(input logic [1:0] conf, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        case (conf)
            MCONF_NIB:    r = {b[3:0], b[7:4]};
            MCONF_PAIR:   r = {b[1:0], b[3:2], b[5:4], b[7:6]};
            MCONF_BITREV: for (int i = 0; i < 8; i++) r[i] = b[7-i];
            default:      r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry AXI-Stream buffer: output register plus one skid register,
// with a registered input ready so downstream ready never reaches upstream combinationally.
module axis_skid_buf
    import matlab_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        push        = in_valid & ready_q;
        pop         = (state_q != SKID_EMPTY) & out_ready;
        case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    out_data_d = in_data;
                    state_d    = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    out_data_d = in_data;
                end else if (push) begin
                    skid_data_d = in_data;
                    state_d     = SKID_FULL;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // ready_q is low here, so only a pop can happen.
                if (pop) begin
                    out_data_d = skid_data_q;
                    state_d    = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        ready_d = (state_d != SKID_FULL);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            ready_q     <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = out_data_q;

endmodule

// File: rtl/matlab_stream_restore.sv
// Receive-side MATLAB restore: locks the reorder mode per packet, undoes the byte
// permutation, buffers through a 2-entry skid buffer and counts delivered beats/packets.
module matlab_stream_restore
    import matlab_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PKT_CNT_W  = 16,
    parameter int BEAT_CNT_W = 16
) (
    input  logic                  S_APB_aclk,
    input  logic                  S_APB_aresetn,
    input  logic [DATA_W-1:0]     S_AXIS_tdata,
    input  logic                  S_AXIS_tvalid,
    input  logic                  S_AXIS_tkeep,
    input  logic                  S_AXIS_tlast,
    output logic                  S_AXIS_tready,
    input  logic [1:0]            MATLABconf,
    output logic [DATA_W-1:0]     M_AXIS_tdata,
    output logic                  M_AXIS_tvalid,
    output logic                  M_AXIS_tkeep,
    output logic                  M_AXIS_tlast,
    input  logic                  M_AXIS_tready,
    output logic [1:0]            conf_active,
    output logic [PKT_CNT_W-1:0]  pkt_count,
    output logic [BEAT_CNT_W-1:0] beat_count
);

    logic                  in_pkt_q, in_pkt_d;
    logic [1:0]            conf_q, conf_d;
    logic [1:0]            eff_conf;
    logic [PKT_CNT_W-1:0]  pkt_q, pkt_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic                  s_ready;
    logic                  accept;
    logic                  out_hs;
    logic [DATA_W-1:0]     perm_data;
    logic [DATA_W+1:0]     buf_in, buf_out;

    assign accept = S_AXIS_tvalid & s_ready;
    assign out_hs = M_AXIS_tvalid & M_AXIS_tready;

    // The first beat of a packet runs on the live mode and locks it for the rest.
    always_comb begin
        in_pkt_d = in_pkt_q;
        conf_d   = conf_q;
        eff_conf = in_pkt_q ? conf_q : MATLABconf;
        if (accept) begin
            if (!in_pkt_q) conf_d = MATLABconf;
            in_pkt_d = !S_AXIS_tlast;
        end
    end

    always_comb begin
        pkt_d  = pkt_q;
        beat_d = beat_q;
        if (out_hs) begin
            if (M_AXIS_tlast) begin
                pkt_d  = pkt_q + PKT_CNT_W'(1);
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
        if (!S_APB_aresetn) begin
            in_pkt_q <= 1'b0;
            conf_q   <= MCONF_NONE;
            pkt_q    <= '0;
            beat_q   <= '0;
        end else begin
            in_pkt_q <= in_pkt_d;
            conf_q   <= conf_d;
            pkt_q    <= pkt_d;
            beat_q   <= beat_d;
        end
    end

    assign perm_data = matlab_perm(eff_conf, S_AXIS_tdata);
    assign buf_in    = {S_AXIS_tlast, S_AXIS_tkeep, perm_data};

    axis_skid_buf #(
        .W (DATA_W + 2)
    ) u_skid (
        .clk       (S_APB_aclk),
        .rst_n     (S_APB_aresetn),
        .in_data   (buf_in),
        .in_valid  (S_AXIS_tvalid),
        .in_ready  (s_ready),
        .out_data  (buf_out),
        .out_valid (M_AXIS_tvalid),
        .out_ready (M_AXIS_tready)
    );

    assign {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata} = buf_out;
    assign S_AXIS_tready = s_ready;
    assign conf_active   = conf_q;
    assign pkt_count     = pkt_q;
    assign beat_count    = beat_q;

endmodule
